// File: rtl/std_alu_arbiter_if.sv
// Requester-side bus of the shared ALU: per-requester go/op/operands in, shared result,
// one-hot done and grant status out.
interface std_alu_arbiter_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 3
);
  logic [NUM_REQ-1:0]       go;
  logic [3*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] left;
  logic [WIDTH*NUM_REQ-1:0] right;
  logic [WIDTH-1:0]         out;
  logic [NUM_REQ-1:0]       done;
  logic [PTR_WIDTH-1:0]     grant_idx;
  logic                     busy;

  modport master (
    output go, op, left, right,
    input  out, done, grant_idx, busy
  );

  modport slave (
    input  go, op, left, right,
    output out, done, grant_idx, busy
  );
endinterface

// File: rtl/std_alu_arbiter.sv
// One ALU time-shared among NUM_REQ go/done requesters (IDLE -> EXEC -> DONE).
// Define STD_ALU_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module std_alu_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 3
) (
  input logic              clk,
  input logic              reset,
  std_alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_SUB = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_RSH = 3'd4,
    OP_LT  = 3'd5,
    OP_EQ  = 3'd6,
    OP_GE  = 3'd7
  } alu_op_e;

  if (int'(PTR_WIDTH) < $clog2(NUM_REQ)) begin : g_ptr_width_chk
    $error("std_alu_arbiter: PTR_WIDTH too small for NUM_REQ");
  end

  state_e               state_q, state_d;
  alu_op_e              op_q, op_d;
  logic [WIDTH-1:0]     left_q, left_d;
  logic [WIDTH-1:0]     right_q, right_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [PTR_WIDTH-1:0] grant_idx_q, grant_idx_d;
`ifndef STD_ALU_ARB_FIXED_PRI_EN
  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
`endif
  logic [WIDTH-1:0]     alu_res;
  logic                 found;

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_SUB: alu_res = left_q - right_q;
      OP_AND: alu_res = left_q & right_q;
      OP_OR:  alu_res = left_q | right_q;
      OP_XOR: alu_res = left_q ^ right_q;
      // Whole right operand is the shift amount; anything >= WIDTH flushes to zero.
      OP_RSH: alu_res = (right_q >= WIDTH'(WIDTH)) ? '0 : (left_q >> right_q);
      OP_LT:  alu_res = WIDTH'(left_q < right_q);
      OP_EQ:  alu_res = WIDTH'(left_q == right_q);
      OP_GE:  alu_res = WIDTH'(left_q >= right_q);
      default: alu_res = '0;
    endcase
  end

  always_comb begin : next_state
    int unsigned start;
    int unsigned idx;
    state_d     = state_q;
    op_d        = op_q;
    left_d      = left_q;
    right_d     = right_q;
    out_d       = out_q;
    grant_idx_d = grant_idx_q;
`ifndef STD_ALU_ARB_FIXED_PRI_EN
    rr_ptr_d    = rr_ptr_q;
    start       = 32'(rr_ptr_q);
`else
    start       = 0;
`endif
    found       = 1'b0;
    idx         = 0;

    case (state_q)
      ST_IDLE: begin
        // Scan from the start pointer with wrap; first set go wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          idx = start + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!found && bus.go[idx]) begin
            found       = 1'b1;
            grant_idx_d = PTR_WIDTH'(idx);
            op_d        = alu_op_e'(bus.op[3*idx +: 3]);
            left_d      = bus.left[WIDTH*idx +: WIDTH];
            right_d     = bus.right[WIDTH*idx +: WIDTH];
          end
        end
        if (found) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        out_d   = alu_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
`ifndef STD_ALU_ARB_FIXED_PRI_EN
        rr_ptr_d = (grant_idx_q == PTR_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : grant_idx_q + PTR_WIDTH'(1);
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SUB;
      left_q      <= '0;
      right_q     <= '0;
      out_q       <= '0;
      grant_idx_q <= '0;
`ifndef STD_ALU_ARB_FIXED_PRI_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_q       <= out_d;
      grant_idx_q <= grant_idx_d;
`ifndef STD_ALU_ARB_FIXED_PRI_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    bus.done = '0;
    if (state_q == ST_DONE) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_idx_q == PTR_WIDTH'(i)) bus.done[i] = 1'b1;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = (state_q == ST_EXEC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_std_alu_arbiter.sv
// Directed self-checking bench for std_alu_arbiter (WIDTH=32, NUM_REQ=4).
module tb_std_alu_arbiter;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned PTR_WIDTH = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  std_alu_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .PTR_WIDTH(PTR_WIDTH)) bus ();

  std_alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .PTR_WIDTH(PTR_WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [31:0] l,
                         input logic [31:0] r);
    bus.op[3*i +: 3]         = o;
    bus.left[WIDTH*i +: WIDTH]  = l;
    bus.right[WIDTH*i +: WIDTH] = r;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    bus.go = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One grant with go held by the caller: grant, result+done, back to idle.
  task automatic grant_seq(input string tag, input int exp_idx, input logic [31:0] exp_out);
    tick();
    check_eq({tag, "_grant"}, 32'(bus.grant_idx), 32'(exp_idx));
    check_eq({tag, "_busy_exec"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_done_exec"}, 32'(bus.done), 32'd0);
    tick();
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1 << exp_idx);
    check_eq({tag, "_out"}, bus.out, exp_out);
    tick();
    check_eq({tag, "_done_idle"}, 32'(bus.done), 32'd0);
  endtask

  // Single-requester op; operands and go are scrambled right after grant.
  task automatic run_op(input string tag, input int idx, input logic [2:0] o,
                        input logic [31:0] l, input logic [31:0] r, input logic [31:0] exp);
    set_req(idx, o, l, r);
    bus.go      = '0;
    bus.go[idx] = 1'b1;
    tick();
    check_eq({tag, "_grant"}, 32'(bus.grant_idx), 32'(idx));
    bus.go = '0;
    set_req(idx, ~o, ~l, r + 32'd3);
    tick();
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1 << idx);
    check_eq({tag, "_out"}, bus.out, exp);
    tick();
  endtask

  int exp_four [5];
  int exp_two  [4];

  initial begin
    bus.go    = '0;
    bus.op    = '0;
    bus.left  = '0;
    bus.right = '0;

    // Reset and idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      check_eq("idle_out", bus.out, 32'd0);
      check_eq("idle_done", 32'(bus.done), 32'd0);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
      check_eq("idle_grant", 32'(bus.grant_idx), 32'd0);
      tick();
    end

    // Single op: 5 - 7 on requester 1
    set_req(1, 3'd0, 32'd5, 32'd7);
    bus.go = 4'b0010;
    tick();
    check_eq("single_grant", 32'(bus.grant_idx), 32'd1);
    check_eq("single_busy", 32'(bus.busy), 32'd1);
    check_eq("single_done_exec", 32'(bus.done), 32'd0);
    tick();
    check_eq("single_done", 32'(bus.done), 32'h2);
    check_eq("single_out", bus.out, 32'hFFFF_FFFE);
    bus.go = '0;
    tick();
    check_eq("single_done_width", 32'(bus.done), 32'd0);
    check_eq("single_busy_idle", 32'(bus.busy), 32'd0);
    check_eq("single_out_hold", bus.out, 32'hFFFF_FFFE);

    // Opcode sweep, requester 3
    run_op("sub_wrap", 3, 3'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_op("and", 3, 3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    run_op("or", 3, 3'd2, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    run_op("xor", 3, 3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    run_op("rsh31", 3, 3'd4, 32'h8000_0000, 32'd31, 32'd1);
    run_op("rsh4", 3, 3'd4, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_op("rsh32", 3, 3'd4, 32'h8000_0000, 32'd32, 32'd0);
    run_op("rsh40", 3, 3'd4, 32'h8000_0000, 32'd40, 32'd0);
    run_op("lt_big", 3, 3'd5, 32'h8000_0000, 32'd31, 32'd0);
    run_op("lt_uns", 3, 3'd5, 32'd3, 32'h8000_0000, 32'd1);
    run_op("eq_t", 3, 3'd6, 32'd7, 32'd7, 32'd1);
    run_op("eq_f", 3, 3'd6, 32'd7, 32'd8, 32'd0);
    run_op("ge_big", 3, 3'd7, 32'h8000_0000, 32'd31, 32'd1);
    run_op("ge_eq", 3, 3'd7, 32'd5, 32'd5, 32'd1);
    run_op("ge_f", 3, 3'd7, 32'd4, 32'd5, 32'd0);
    run_op("slice0", 0, 3'd0, 32'd100, 32'd58, 32'd42);

    // Contention: all four requesters, and 0xFF & 0x0F
`ifdef STD_ALU_ARB_FIXED_PRI_EN
    exp_four = '{0, 0, 0, 0, 0};
    exp_two  = '{1, 1, 1, 1};
`else
    exp_four = '{0, 1, 2, 3, 0};
    exp_two  = '{1, 3, 1, 3};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'd1, 32'hFF, 32'h0F);
    bus.go = 4'b1111;
    foreach (exp_four[g]) grant_seq("contend", exp_four[g], 32'h0F);
    bus.go = '0;

    // Reset during EXEC of requester 2
    set_req(2, 3'd0, 32'd100, 32'd1);
    bus.go = 4'b0100;
    tick();
    check_eq("midrst_grant", 32'(bus.grant_idx), 32'd2);
    reset = 1'b0;
    tick();
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_out", bus.out, 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_gidx", 32'(bus.grant_idx), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("regrant_idx", 32'(bus.grant_idx), 32'd2);
    check_eq("regrant_busy", 32'(bus.busy), 32'd1);
    check_eq("regrant_nodone", 32'(bus.done), 32'd0);
    bus.go = '0;
    tick();
    check_eq("regrant_done", 32'(bus.done), 32'h4);
    check_eq("regrant_out", bus.out, 32'd99);
    tick();

    // Two requesters 1 and 3 held high
    do_reset();
    set_req(1, 3'd2, 32'd1, 32'd0);
    set_req(3, 3'd2, 32'd3, 32'd0);
    bus.go = 4'b1010;
    foreach (exp_two[g]) grant_seq("pair", exp_two[g], 32'(exp_two[g]));
    bus.go = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/std_alu_arbiter.md
Name: std_alu_arbiter

Overview:
- Shares one ALU datapath among NUM_REQ requesters. The ALU covers sub, and, or, xor, rsh and the unsigned compares.
- Each requester uses the Calyx go/done handshake. The block arbitrates, captures the winner's operands, computes, registers the result and pulses that requester's done.
- Used by the compiler's resource-sharing lowering so that multiple groups can time-share a single ALU instance.

Parameters:
- WIDTH, 32, operand and result width in bits.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- PTR_WIDTH, 3, width of the grant index; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- go  input  NUM_REQ  go[i] high = requester i requests an operation; held until done[i].
- op  input  3*NUM_REQ  op[3i+2:3i] is requester i's opcode.
- left  input  WIDTH*NUM_REQ  requester i's left operand is slice [WIDTH*(i+1)-1 : WIDTH*i].
- right  input  WIDTH*NUM_REQ  requester i's right operand, same slicing as left.
- out  output  WIDTH  registered result of the most recent operation.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- grant_idx  output  PTR_WIDTH  index of the current or last granted requester.
- busy  output  1  high in EXEC and DONE states.

Behaviour:
- Reset (reset==0 at a clock edge) sets: state=IDLE, out=0, done=0, grant_idx=0, busy=0, rr_ptr=0. Reset overrides everything, including an in-flight operation; no done is issued for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any go[i] is set, select winner w by round-robin: the first set go[] at or after rr_ptr, wrapping modulo NUM_REQ.
  - Capture op/left/right of w into internal registers, set grant_idx=w, go to EXEC.
  - If no go[] is set, stay in IDLE.
- EXEC:
  - Compute on the captured operands and register the result into out. Go to DONE.
- DONE:
  - done[grant_idx]=1 for exactly this cycle; out is valid.
  - rr_ptr <= (grant_idx+1) mod NUM_REQ. Go to IDLE.
  - No arbitration happens in DONE, so a requester's go that is still high during its own done cycle is not re-granted.
- Latency and throughput: go seen in IDLE at cycle t gives done at t+2. Maximum throughput is one operation per 3 cycles.
- Opcodes:
  - 0 = left-right, modulo 2^WIDTH.
  - 1 = and; 2 = or; 3 = xor.
  - 4 = left>>right, logical shift using the full right operand; right >= WIDTH gives 0.
  - 5 = lt, 6 = eq, 7 = ge. All compares are unsigned; the 1-bit result is zero-extended to WIDTH.
- out holds its value outside DONE until the next EXEC overwrites it.
- Operands are sampled only at grant. Changes to left/right/op after grant are ignored.
- go[w] deasserted after grant: the operation still completes and done[w] still pulses.
- Simultaneous requests are resolved strictly by rr_ptr. No requester waits more than NUM_REQ-1 grants.
- go bits for indices >= NUM_REQ do not exist. If PTR_WIDTH < clog2(NUM_REQ), raise $error under VERILATOR.

Optional Feature:
- Macro: STD_ALU_ARB_FIXED_PRI_EN.
- Defined: fixed priority. The lowest-index set go[] always wins; rr_ptr is not implemented and its update is removed. Starvation of high indices is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then go=0 -> out=0, done=0, busy=0, grant_idx=0 and all stay at those values for 10 cycles.
- Single op: go[1]=1, op1=0, left1=5, right1=7, WIDTH=32 -> done[1] pulses 2 cycles after grant with out=32'hFFFFFFFE; done is one cycle wide.
- Contention (round-robin): go=4'b1111 held continuously, all ops and=0xFF&0x0F -> done order 0,1,2,3,0, grants 3 cycles apart, out=0x0F each time.
- Opcode sweep: left=0x80000000, right=31 -> op4 out=1, op5 out=0, op7 out=1; right=40 with op4 -> out=0.
- Reset mid-op: assert reset=0 in the EXEC cycle of a grant to requester 2 -> no done[2] pulse, state IDLE, out=0; the next go=4'b0100 is granted with grant_idx=2.
- Fixed priority (macro defined): go=4'b1010 held continuously -> requester 1 is granted every time and requester 3 is never granted.
